// File: rtl/yk_axil_pkg.sv
// rtl/yk_axil_pkg.sv - shared AXI-Lite response codes, slave state encoding and address helper
//
// Purpose : constants and types shared by the AXI-Lite RAM slave and its RAM bank.
// Contents: RESP_OKAY / RESP_SLVERR response codes, axil_state_e slave FSM encoding,
//           addr_in_range() window test used when AXIL_RAM_BOUNDS_EN is defined.
package yk_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_COLLECT = 2'd1,
    RD_RESP    = 2'd2,
    WR_RESP    = 2'd3
  } axil_state_e;

  // 33-bit compare so a window ending exactly at 4 GiB does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span_bytes);
    logic [32:0] end_excl;
    end_excl = {1'b0, base} + span_bytes;
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < end_excl);
  endfunction

endpackage

// File: rtl/axil_ram_bank.sv
// rtl/axil_ram_bank.sv - single-port synchronous-read RAM with per-byte write enables
//
// Purpose : DEPTH_WORDS x 32 storage for axil_ram_slave. Contents are never reset.
// Ports   : clk      - clock
//           i_re     - read enable; o_rdata loads mem[i_addr] on the edge, else holds
//           i_we     - per-byte write enables, byte i = i_wdata[8i+7:8i]
//           i_addr   - word index shared by read and write
//           i_wdata  - write data
//           o_rdata  - registered read data (one-cycle latency)
module axil_ram_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_re,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/axil_ram_slave.sv
// rtl/axil_ram_slave.sv - AXI-Lite slave fronting a byte-writable 32-bit RAM
//
// Purpose : one-transaction-at-a-time AXI-Lite RAM. Reads have priority over writes
//           when both address channels are valid in IDLE. Read data arrives one
//           cycle after the AR handshake; the B response one cycle after the write
//           commits. AW and W may arrive in either order or together.
// Macro   : AXIL_RAM_BOUNDS_EN - when defined, addresses outside
//           [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) answer SLVERR, read data 0 and
//           writes are dropped. When undefined, addresses alias modulo DEPTH_WORDS
//           and every response is OKAY.
// Ports   : clk, rstn                 - clock, synchronous active-low reset
//           s_axi_ar* / s_axi_r*      - read address / read data channels
//           s_axi_aw* / s_axi_w*      - write address / write data channels
//           s_axi_b*                  - write response channel
module axil_ram_slave
  import yk_axil_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  axil_state_e r_state;
  axil_state_e w_state_nxt;

  logic        r_aw_got;
  logic        r_w_got;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;

  logic        w_arready;
  logic        w_awready;
  logic        w_wready;
  logic        w_rvalid;
  logic        w_bvalid;

  logic        w_ar_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_commit;

  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [31:0] w_rd_off;
  logic [31:0] w_wr_off;
  logic        w_rd_oob;
  logic        w_wr_oob;
  logic        w_unused_off_bits;

  logic [AW-1:0] w_bank_addr;
  logic [3:0]    w_bank_we;
  logic [31:0]   w_bank_rdata;

  // Handshakes are masked during reset so a beat presented while rstn is low
  // can never commit a half-collected write.
  assign w_ar_hs = rstn && s_axi_arvalid && w_arready;
  assign w_aw_hs = rstn && s_axi_awvalid && w_awready;
  assign w_w_hs  = rstn && s_axi_wvalid  && w_wready;

  // The write commits on the edge where the second of AW/W is accepted.
  assign w_commit = ((r_state == IDLE) && w_aw_hs && w_w_hs) ||
                    ((r_state == WR_COLLECT) &&
                     ((w_aw_hs && r_w_got) || (w_w_hs && r_aw_got)));

  // Whichever half arrives on the commit edge comes straight from the bus.
  assign w_wr_addr = w_aw_hs ? s_axi_awaddr : r_awaddr;
  assign w_wr_data = w_w_hs  ? s_axi_wdata  : r_wdata;
  assign w_wr_strb = w_w_hs  ? s_axi_wstrb  : r_wstrb;

  assign w_rd_off = s_axi_araddr - BASE_ADDR;
  assign w_wr_off = w_wr_addr - BASE_ADDR;
  assign w_unused_off_bits = ^{w_rd_off[31:AW+2], w_rd_off[1:0],
                               w_wr_off[31:AW+2], w_wr_off[1:0]};

`ifdef AXIL_RAM_BOUNDS_EN
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  assign w_rd_oob = !addr_in_range(s_axi_araddr, BASE_ADDR, SPAN_BYTES);
  assign w_wr_oob = !addr_in_range(w_wr_addr, BASE_ADDR, SPAN_BYTES);
`else
  assign w_rd_oob = 1'b0;
  assign w_wr_oob = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ar_hs) begin
          w_state_nxt = RD_RESP;
        end else if (w_commit) begin
          w_state_nxt = WR_RESP;
        end else if (w_aw_hs || w_w_hs) begin
          w_state_nxt = WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        if (w_commit) begin
          w_state_nxt = WR_RESP;
        end
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          w_state_nxt = IDLE;
        end
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_arready = (r_state == IDLE);
    w_awready = ((r_state == IDLE) && !s_axi_arvalid) ||
                ((r_state == WR_COLLECT) && !r_aw_got);
    w_wready  = ((r_state == IDLE) && !s_axi_arvalid) ||
                ((r_state == WR_COLLECT) && !r_w_got);
    w_rvalid  = (r_state == RD_RESP);
    w_bvalid  = (r_state == WR_RESP);
  end

  // Capture registers for a write collected over several cycles, plus responses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= 32'h0;
      r_wdata  <= 32'h0;
      r_wstrb  <= 4'h0;
      r_rresp  <= RESP_OKAY;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
      if (w_ar_hs) begin
        r_rresp <= w_rd_oob ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_commit) begin
        r_bresp <= w_wr_oob ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_bvalid && s_axi_bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
    end
  end

  // Reads and writes never coincide (one transaction outstanding), so the
  // single RAM port is shared by muxing on the AR handshake.
  assign w_bank_addr = w_ar_hs ? w_rd_off[AW+1:2] : w_wr_off[AW+1:2];
  assign w_bank_we   = (w_commit && !w_wr_oob) ? w_wr_strb : 4'b0000;

  axil_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_bank (
    .clk     (clk),
    .i_re    (w_ar_hs),
    .i_we    (w_bank_we),
    .i_addr  (w_bank_addr),
    .i_wdata (w_wr_data),
    .o_rdata (w_bank_rdata)
  );

  // The RAM output register is not reset and holds the last word read; data
  // is only exposed during an OKAY read response, which also zeroes SLVERR data.
  assign s_axi_rdata   = (w_rvalid && (r_rresp == RESP_OKAY)) ? w_bank_rdata : 32'h0;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_arready = w_arready;
  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = w_bvalid;

endmodule

// File: tb/tb_axil_ram_slave.sv
// tb/tb_axil_ram_slave.sv - directed self-checking bench for axil_ram_slave
module tb_axil_ram_slave;

  logic        clk;
  logic        rstn;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  int n_checks = 0;
  int n_errors = 0;

  axil_ram_slave #(
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // aw_start / w_start: cycle index (from task entry) at which each channel goes valid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_start, input int w_start,
                           input logic [1:0] exp_resp);
    int   c;
    logic aw_done, w_done, aw_f, w_f;
    c = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && c < 40) begin
      if (!aw_done && c >= aw_start) begin
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
      end
      if (!w_done && c >= w_start) begin
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb;
      end
      #1;
      aw_f = s_axi_awvalid && s_axi_awready;
      w_f  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); @(negedge clk);
      if (aw_f) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_f)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
      c++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("wr_hs_done", {30'b0, aw_done, w_done}, 32'h3);
    check("b_latency", {31'b0, s_axi_bvalid}, 32'h1);
    check("bresp", {30'b0, s_axi_bresp}, {30'b0, exp_resp});
    s_axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_bready = 1'b0;
    check("b_clear", {31'b0, s_axi_bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int c;
    c = 0;
    s_axi_arvalid = 1'b1; s_axi_araddr = addr;
    #1;
    while (!s_axi_arready && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check("ar_ready", {31'b0, s_axi_arready}, 32'h1);
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("r_latency", {31'b0, s_axi_rvalid}, 32'h1);
    data = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_rready = 1'b0;
    check("r_clear", {31'b0, s_axi_rvalid}, 32'h0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;

  initial begin
    rstn = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_rvalid", {31'b0, s_axi_rvalid}, 32'h0);
    check("rst_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_rresp", {30'b0, s_axi_rresp}, 32'h0);
    check("rst_bresp", {30'b0, s_axi_bresp}, 32'h0);
    check("rst_arready", {31'b0, s_axi_arready}, 32'h1);
    check("rst_awready", {31'b0, s_axi_awready}, 32'h1);

    // full-word write with AW and W together, then read back
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00);
    axi_read(32'h10, rd, rr);
    check("rd_10", rd, 32'hDEAD_BEEF);
    check("rresp_10", {30'b0, rr}, 32'h0);

    // W two cycles ahead of AW, partial strobe
    axi_write(32'h10, 32'h1122_3344, 4'b0101, 2, 0, 2'b00);
    axi_read(32'h10, rd, rr);
    check("rd_strb", rd, 32'hDE22_BE44);

    // AW ahead of W; low address bits ignored on read
    axi_write(32'h24, 32'hCAFE_F00D, 4'hF, 0, 3, 2'b00);
    axi_read(32'h27, rd, rr);
    check("rd_aw_first", rd, 32'hCAFE_F00D);

    // wstrb = 0 writes nothing but still answers OKAY
    axi_write(32'h24, 32'h0000_0000, 4'h0, 0, 0, 2'b00);
    axi_read(32'h24, rd, rr);
    check("rd_strb0", rd, 32'hCAFE_F00D);

    // read priority: AR and AW+W valid together in IDLE
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h20;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h55AA_55AA; s_axi_wstrb = 4'hF;
    #1;
    check("prio_arready", {31'b0, s_axi_arready}, 32'h1);
    check("prio_awready", {31'b0, s_axi_awready}, 32'h0);
    check("prio_wready", {31'b0, s_axi_wready}, 32'h0);
    @(posedge clk); @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("prio_rvalid", {31'b0, s_axi_rvalid}, 32'h1);
    check("prio_rdata", s_axi_rdata, 32'hDE22_BE44);
    check("prio_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
    check("prio_awready_rd", {31'b0, s_axi_awready}, 32'h0);
    s_axi_rready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_rready = 1'b0;
    #1;
    check("prio_awready_after", {31'b0, s_axi_awready}, 32'h1);
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("prio_bvalid_after", {31'b0, s_axi_bvalid}, 32'h1);
    check("prio_rvalid_after", {31'b0, s_axi_rvalid}, 32'h0);
    s_axi_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_bready = 1'b0;
    axi_read(32'h20, rd, rr);
    check("rd_prio_write", rd, 32'h55AA_55AA);

    // rready stalled 5 cycles while another AR is pending
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h24;
    @(posedge clk); @(negedge clk);
    s_axi_araddr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", {31'b0, s_axi_rvalid}, 32'h1);
      check("stall_rdata", s_axi_rdata, 32'hCAFE_F00D);
      check("stall_arready", {31'b0, s_axi_arready}, 32'h0);
      @(posedge clk); @(negedge clk);
    end
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_axi_rready = 1'b0;
    check("stall_rclear", {31'b0, s_axi_rvalid}, 32'h0);

    // reset with only AW captured; W offered during reset must not commit
    axi_write(32'h30, 32'h1234_5678, 4'hF, 0, 0, 2'b00);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h30;
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 1'b0;
    rstn = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF;
    @(posedge clk); @(negedge clk);
    s_axi_wvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    check("rst_mid_rvalid", {31'b0, s_axi_rvalid}, 32'h0);
    check("rst_mid_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
    check("rst_mid_awready", {31'b0, s_axi_awready}, 32'h1);
    @(negedge clk);
    check("rst_mid_bvalid2", {31'b0, s_axi_bvalid}, 32'h0);
    axi_read(32'h30, rd, rr);
    check("rd_after_abort", rd, 32'h1234_5678);

    // out-of-window access at 0x4000 (DEPTH_WORDS = 4096 -> 16 KiB window)
    axi_write(32'h0, 32'hA5A5_0001, 4'hF, 0, 0, 2'b00);
`ifdef AXIL_RAM_BOUNDS_EN
    axi_read(32'h4000, rd, rr);
    check("oob_rdata", rd, 32'h0);
    check("oob_rresp", {30'b0, rr}, 32'h2);
    axi_write(32'h4000, 32'h7777_7777, 4'hF, 0, 0, 2'b10);
    axi_read(32'h0, rd, rr);
    check("oob_wr_dropped", rd, 32'hA5A5_0001);
`else
    axi_read(32'h4000, rd, rr);
    check("alias_rdata", rd, 32'hA5A5_0001);
    check("alias_rresp", {30'b0, rr}, 32'h0);
    axi_write(32'h4004, 32'h7777_7777, 4'hF, 0, 0, 2'b00);
    axi_read(32'h4, rd, rr);
    check("alias_wr", rd, 32'h7777_7777);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
